// File: rtl/aes_pkg.sv
// Shared AES constants: forward S-box, key-schedule round constant seed,
// xtime reduction polynomial and the key-expansion FSM encoding.
package aes_pkg;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_e;

    // Entry 0 sits in the most significant byte of the concatenation.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/sbox.sv
// Forward AES S-box, one byte, purely combinational table lookup.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    assign y_o = SBOX[a_i];

endmodule

// File: rtl/round_key_gen.sv
// AES key expansion: one schedule word per cycle into a local word store,
// then registered 128-bit round-key reads indexed by round number.
module round_key_gen
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [32*Nk-1:0]  key_in,
    output logic              busy,
    output logic              ready,
    input  logic [3:0]        rd_idx,
    output logic [127:0]      rd_key
);

    localparam int NW = 4 * (Nr + 1);
    localparam int IW = $clog2(NW);
    localparam int MW = $clog2(Nk);

    ks_state_e         state_q;
    logic [IW-1:0]     i_q;
    logic [MW-1:0]     mod_q;
    logic [7:0]        rcon_q;
    logic              busy_q;
    logic              ready_q;
    logic [127:0]      rd_key_q;
    logic [127:0]      rd_key_d;

    logic [31:0]       w_mem [NW];

    logic              load;
    logic [31:0]       prev_w;
    logic [31:0]       sub_in;
    logic [31:0]       sub_out;
    logic [31:0]       temp;
    logic [31:0]       new_w;
    logic [IW-1:0]     base;

    assign load = start && (state_q != ST_EXPAND);

    // temp is built from w[i-1]; RotWord only on the i mod Nk == 0 words.
    assign prev_w = w_mem[i_q - IW'(1)];
    assign sub_in = (mod_q == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_subword
        sbox u_sbox (
            .a_i (sub_in[8*b +: 8]),
            .y_o (sub_out[8*b +: 8])
        );
    end

    always_comb begin
        temp = prev_w;
        if (mod_q == '0)
            temp = sub_out ^ {rcon_q, 24'h0};
        else if (Nk == 8 && int'(mod_q) == 4)
            temp = sub_out;
    end

    assign new_w = w_mem[i_q - IW'(Nk)] ^ temp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            mod_q   <= '0;
            rcon_q  <= RCON_INIT;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_EXPAND;
                        i_q     <= IW'(Nk);
                        mod_q   <= '0;
                        rcon_q  <= RCON_INIT;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    i_q   <= i_q + IW'(1);
                    mod_q <= (mod_q == MW'(Nk - 1)) ? '0 : mod_q + MW'(1);
                    if (mod_q == '0)
                        rcon_q <= xtime(rcon_q);
                    if (i_q == IW'(NW - 1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Word store is deliberately not reset; ready_q gates what is visible.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (load) begin
                for (int k = 0; k < Nk; k++)
                    w_mem[k] <= key_in[32*(Nk-1-k) +: 32];
            end else if (state_q == ST_EXPAND) begin
                w_mem[i_q] <= new_w;
            end
        end
    end

    assign base = IW'({(rd_idx <= 4'(Nr)) ? rd_idx : 4'd0, 2'b00});

    // An accepted start blanks the output immediately, not one cycle later.
    always_comb begin
        rd_key_d = 128'h0;
        if (ready_q && !start && rd_idx <= 4'(Nr))
            rd_key_d = {w_mem[base], w_mem[base + IW'(1)],
                        w_mem[base + IW'(2)], w_mem[base + IW'(3)]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rd_key_q <= 128'h0;
        else
            rd_key_q <= rd_key_d;
    end

    assign busy   = busy_q;
    assign ready  = ready_q;
    assign rd_key = rd_key_q;

endmodule

// File: tb/tb_round_key_gen.sv
// Scoreboard bench for round_key_gen with Nk=4/6/8 instances side by side.
module tb_round_key_gen;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [191:0] KEY_6  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] K6_R0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] K6_R12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] KEY_8  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K8_R1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] K8_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

    localparam int SEL_KEY = 0, SEL_RDY = 1, SEL_BSY = 2, SEL_BCNT = 3;

    typedef struct {
        int           sel;
        int           d;
        logic [127:0] exp;
        string        name;
    } chk_t;

    logic                  clk;
    logic                  rst_n;
    logic [2:0]            st;
    logic [2:0]            rdy;
    logic [2:0]            bsy;
    logic [2:0][3:0]       idx;
    logic [2:0][127:0]     rk;
    logic [127:0]          key4;
    logic [191:0]          key6;
    logic [255:0]          key8;

    int   bcnt [3];
    int   n_cmp = 0;
    int   n_err = 0;
    chk_t sb [$];

    round_key_gen #(.Nk(4), .Nr(10)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .key_in(key4),
        .busy(bsy[0]), .ready(rdy[0]), .rd_idx(idx[0]), .rd_key(rk[0]));
    round_key_gen #(.Nk(6), .Nr(12)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .key_in(key6),
        .busy(bsy[1]), .ready(rdy[1]), .rd_idx(idx[1]), .rd_key(rk[1]));
    round_key_gen #(.Nk(8), .Nr(14)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .key_in(key8),
        .busy(bsy[2]), .ready(rdy[2]), .rd_idx(idx[2]), .rd_key(rk[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++)
            if (bsy[d]) bcnt[d]++;
    end

    function automatic logic [127:0] actual(input int sel, input int d);
        case (sel)
            SEL_KEY: return rk[d];
            SEL_RDY: return {127'h0, rdy[d]};
            SEL_BSY: return {127'h0, bsy[d]};
            default: return 128'(bcnt[d]);
        endcase
    endfunction

    // Monitor: everything queued before an edge is checked just after it.
    initial begin
        chk_t c;
        logic [127:0] act;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (bsy[d] && rdy[d]) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL overlap dut%0d: busy=1 ready=1, required not both", d);
                end
            end
            while (sb.size() > 0) begin
                c   = sb.pop_front();
                act = actual(c.sel, c.d);
                n_cmp++;
                if (act !== c.exp) begin
                    n_err++;
                    $display("FAIL %s dut%0d: got %h, required %h", c.name, c.d, act, c.exp);
                end
            end
        end
    end

    task automatic expect_v(input int sel, input int d, input logic [127:0] e, input string nm);
        chk_t c;
        c.sel = sel; c.d = d; c.exp = e; c.name = nm;
        sb.push_back(c);
    endtask

    task automatic rd(input int d, input logic [3:0] r, input logic [127:0] e, input string nm);
        idx[d] = r;
        expect_v(SEL_KEY, d, e, nm);
    endtask

    task automatic kick(input int d);
        st[d]   = 1'b1;
        bcnt[d] = 0;
    endtask

    task automatic wait_ready(input int d, input int busy_cycles);
        logic prev;
        prev = bsy[d];
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rdy[d]) begin
                n_cmp++;
                if (prev !== 1'b1) begin
                    n_err++;
                    $display("FAIL ready_edge dut%0d: busy before ready=%b, required 1", d, prev);
                end
                expect_v(SEL_BCNT, d, 128'(busy_cycles), "busy_cycles");
                return;
            end
            prev = bsy[d];
        end
        n_cmp++;
        n_err++;
        $display("FAIL ready_timeout dut%0d: ready=0 after 200 cycles, required 1", d);
    endtask

    initial begin
        rst_n = 1'b0;
        st    = '0;
        idx   = '0;
        key4  = KEY_A;
        key6  = KEY_6;
        key8  = KEY_8;
        for (int d = 0; d < 3; d++) bcnt[d] = 0;

        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            expect_v(SEL_BSY, d, 128'h0, "reset_busy");
            expect_v(SEL_RDY, d, 128'h0, "reset_ready");
            expect_v(SEL_KEY, d, 128'h0, "reset_rdkey");
        end
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        kick(0); kick(1); kick(2);
        @(negedge clk);
        st = '0;
        wait_ready(0, 40);
        wait_ready(1, 46);
        wait_ready(2, 52);
        rd(0, 4'd1, A_R1, "nk4_r1");
        @(negedge clk);
        rd(0, 4'd10, A_R10, "nk4_r10");
        rd(1, 4'd12, K6_R12, "nk6_r12");
        rd(2, 4'd14, K8_R14, "nk8_r14");
        @(negedge clk);
        rd(0, 4'd0, KEY_A, "nk4_r0");
        rd(1, 4'd0, K6_R0, "nk6_r0");
        rd(2, 4'd1, K8_R1, "nk8_r1");
        @(negedge clk);
        rd(0, 4'd15, 128'h0, "nk4_idx15");
        rd(1, 4'd13, 128'h0, "nk6_idx13");
        expect_v(SEL_RDY, 0, 128'h1, "ready_held");
        @(negedge clk);

        // Restart from DONE: output blanks at once and stays blank.
        kick(0);
        rd(0, 4'd1, 128'h0, "restart_rdkey");
        expect_v(SEL_RDY, 0, 128'h0, "restart_ready");
        @(negedge clk);
        st[0] = 1'b0;
        expect_v(SEL_KEY, 0, 128'h0, "restart_rdkey_exp");
        wait_ready(0, 40);
        rd(0, 4'd1, A_R1, "restart_r1");
        @(negedge clk);

        // All-zero key, with a second start (and a new key) mid-expansion.
        key4 = 128'h0;
        kick(0);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (9) @(negedge clk);
        key4  = KEY_A;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        wait_ready(0, 40);
        rd(0, 4'd10, Z_R10, "zero_r10");
        @(negedge clk);

        // Reset in the middle of an expansion.
        kick(0);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        rd(0, 4'd1, 128'h0, "abort_rdkey");
        expect_v(SEL_BSY, 0, 128'h0, "abort_busy");
        expect_v(SEL_RDY, 0, 128'h0, "abort_ready");
        @(negedge clk);
        rst_n = 1'b1;
        expect_v(SEL_RDY, 0, 128'h0, "abort_ready_hold");
        @(negedge clk);
        kick(0);
        @(negedge clk);
        st[0] = 1'b0;
        wait_ready(0, 40);
        rd(0, 4'd1, A_R1, "rerun_r1");
        @(negedge clk);
        rd(0, 4'd10, A_R10, "rerun_r10");
        @(negedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
